// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack, holds the word for decode.
// Optional fetch address check enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus_4_o,
    input  logic        id_ready_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        exc_adel_o
);

`ifdef FETCH_ADDR_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_ERR} state_e;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFF);
    endfunction
`else
    typedef enum logic [1:0] {S_REQ, S_HOLD} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] next_pc;
    logic        load_pc;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ifpc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        next_pc = pc_q + 32'd4;
        load_pc = 1'b0;
        // Redirect wins over everything: a concurrent ack is dropped, a concurrent accept adds nothing.
        if (redirect_valid_i) begin
            next_pc = redirect_pc_i;
            load_pc = 1'b1;
        end else begin
            case (state_q)
                S_REQ: if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    ifpc_d  = pc_q;
                    state_d = S_HOLD;
                end
                S_HOLD: if (id_ready_i) load_pc = 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
                S_ERR: begin
                    pc_d    = EXC_PC;
                    state_d = S_REQ;
                end
`endif
                default: state_d = S_REQ;
            endcase
        end
        if (load_pc) begin
            pc_d    = next_pc;
            state_d = S_REQ;
`ifdef FETCH_ADDR_CHECK_EN
            // A bad target is never loaded; ERR then vectors to the handler.
            if (!addr_ok(next_pc)) begin
                pc_d    = pc_q;
                state_d = S_ERR;
            end
`endif
        end
    end

    assign imem_req_o     = (state_q == S_REQ);
    assign imem_addr_o    = pc_q;
    assign if_valid_o     = (state_q == S_HOLD);
    assign if_instr_o     = instr_q;
    assign if_pc_o        = ifpc_q;
    assign if_pc_plus_4_o = ifpc_q + 32'd4;
`ifdef FETCH_ADDR_CHECK_EN
    assign exc_adel_o     = (state_q == S_ERR);
`else
    assign exc_adel_o     = 1'b0;
`endif

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the multi-cycle MIPS core. It owns the PC register and issues word fetches to instruction memory over a req/ack handshake. It holds each fetched instruction until decode accepts it. It advances the PC by 4 or loads a redirect target supplied by the next-PC logic when a branch or jump resolves taken.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- EXC_PC, 32'h0000_4180, handler address for fetch address errors (used only with the macro)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 resets the block
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  32  fetch address; equals the current PC
- imem_ack  in  1  memory response valid this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- if_valid  out  1  fetched instruction available to decode
- if_instr  out  32  held instruction
- if_pc  out  32  PC of the held instruction
- if_pc_plus_4  out  32  if_pc + 4
- id_ready  in  1  decode accepts the instruction this cycle
- redirect_valid  in  1  taken branch/jump/jr this cycle
- redirect_pc  in  32  target PC
- exc_adel  out  1  fetch address error, one-cycle pulse (macro only; tied 0 otherwise)

## Operation
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: if_valid=1.
  - ERR: macro only.
- REQ:
  - imem_ack=1 → latch imem_rdata to if_instr and pc to if_pc; go to HOLD.
  - imem_ack=0 → stay in REQ. imem_addr stays stable.
- HOLD:
  - id_ready=1 → pc ← pc+4; go to REQ.
  - id_ready=0 → stay in HOLD. if_instr and if_pc stay stable.
- Redirect has top priority in every state:
  - pc ← redirect_pc; go to REQ; if_valid drops the next cycle.
  - A simultaneous imem_ack is discarded.
  - A simultaneous id_ready does not add 4.
- Arithmetic: pc+4 and if_pc+4 wrap modulo 2^32 (0xFFFF_FFFC+4 = 0). There is no carry out.
- Reset values:
  - State REQ, pc=RESET_PC, imem_req=1, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc_plus_4=RESET_PC+4, exc_adel=0.
- Reset asserted mid-transaction: the outstanding request is abandoned immediately. A late imem_ack after reset release is taken as the response for RESET_PC.

## Timing
- imem_ack may arrive in the same cycle as the request (combinational memory) or any number of cycles later.
- Minimum fetch-to-fetch interval is 2 cycles: REQ, ack, HOLD, accept, REQ.
- if_valid rises the cycle after the acking edge.
- Redirect takes effect at the next edge. imem_addr shows redirect_pc in the following cycle.
- All outputs are registered or decoded from the state alone. There is no combinational path from any input to any output.

## Configuration
- FETCH_ADDR_CHECK_EN defined:
  - Before loading any new pc value (pc+4 or redirect_pc), the block checks that bits [1:0]=0 and that the value lies in [0x0000_3000, 0x0000_6FFF].
  - On failure, the block enters ERR for one cycle. In ERR: exc_adel=1, imem_req=0, if_valid=0, pc ← EXC_PC. It then goes to REQ.
  - EXC_PC is not itself checked.
- FETCH_ADDR_CHECK_EN undefined:
  - No check. ERR state and its logic are absent. exc_adel is tied to 0.
  - Misaligned addresses pass through unchanged.

## Test plan
- Release reset with imem_ack tied high and id_ready high → imem_addr sequence 0x3000, 0x3000 (HOLD), 0x3004, …; if_pc_plus_4=0x3004 on the first valid.
- imem_ack delayed 3 cycles at 0x3004 → imem_addr holds 0x3004 and if_valid=0 for 3 cycles; if_instr updates on the ack.
- HOLD with id_ready=0 for 5 cycles → if_instr and if_pc are unchanged; a single pc+4 on accept.
- redirect_valid with redirect_pc=0x3100 in the same cycle as imem_ack for 0x3008 → response dropped, next imem_addr=0x3100, no if_valid for 0x3008.
- Reset pulsed low while in REQ at 0x3010 → imem_addr=0x3000 immediately, if_valid=0.
- With FETCH_ADDR_CHECK_EN defined, redirect_pc=0x3102 → exc_adel pulse of 1 cycle, next imem_addr=0x4180. Without the macro → imem_addr=0x3102.
